// File: rtl/bc_game_ctrl.sv
// bc_game_ctrl: game-level controller behind the bulls-and-cows scorer.
// Counts attempts, decides win/loss against MAX_TRIES and forwards each
// accepted score as a single-entry report on a valid/ready interface.
// Optional feature macro: BC_BEST_TRACK_EN (best winning attempt count).
//
// state | meaning
// IDLE  | waiting for start, results ignored
// PLAY  | game running, legal results accepted
// WON   | last accepted guess had 4 bulls
// LOST  | attempt limit reached without a win
module bc_game_ctrl #(
  parameter int MAX_TRIES = 10,
  parameter int TRY_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             res_valid,
  input  logic [2:0]       res_bulls,
  input  logic [2:0]       res_cows,
  output logic [1:0]       state_o,
  output logic [TRY_W-1:0] tries,
  output logic             game_won,
  output logic             game_lost,
  output logic             rep_valid,
  input  logic             rep_ready,
  output logic [2:0]       rep_bulls,
  output logic [2:0]       rep_cows,
  output logic [TRY_W-1:0] rep_try,
  output logic             err_score,
  output logic             err_overrun,
  output logic [TRY_W-1:0] best_tries
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_WON  = 2'd2;
  localparam logic [1:0] S_LOST = 2'd3;

  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [3:0]       score_sum;
  logic             legal;
  logic             in_play;
  logic             accept;
  logic             win_hit;
  logic [TRY_W-1:0] tries_inc;

  // Sum is widened so 4+4 cannot alias into a small legal value.
  assign score_sum = {1'b0, res_bulls} + {1'b0, res_cows};
  assign legal     = (res_bulls <= 3'd4) && (res_cows <= 3'd4) && (score_sum <= 4'd4);
  assign in_play   = (state_q == S_PLAY);
  assign accept    = in_play && res_valid && legal && !start;
  assign win_hit   = (res_bulls == 3'd4);
  assign tries_inc = tries + TRY_ONE;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; start overrides any simultaneous result.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_PLAY;
    end else if (accept) begin
      if (win_hit)                      state_d = S_WON;
      else if (tries_inc == TRY_LIMIT)  state_d = S_LOST;
    end
  end

  // State-derived outputs (decodes of the state register).
  always_comb begin
    state_o   = state_q;
    game_won  = 1'b0;
    game_lost = 1'b0;
    if (state_q == S_WON)  game_won  = 1'b1;
    if (state_q == S_LOST) game_lost = 1'b1;
  end

  // Attempt counter, report register and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tries       <= '0;
      rep_valid   <= 1'b0;
      rep_bulls   <= '0;
      rep_cows    <= '0;
      rep_try     <= '0;
      err_score   <= 1'b0;
      err_overrun <= 1'b0;
    end else if (start) begin
      tries       <= '0;
      rep_valid   <= 1'b0;
      err_score   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (in_play && res_valid && !legal) err_score <= 1'b1;
      if (accept) begin
        tries     <= tries_inc;
        rep_bulls <= res_bulls;
        rep_cows  <= res_cows;
        rep_try   <= tries_inc;
        rep_valid <= 1'b1;
        if (rep_valid && !rep_ready) err_overrun <= 1'b1;
      end else if (rep_valid && rep_ready) begin
        rep_valid <= 1'b0;
      end
    end
  end

`ifdef BC_BEST_TRACK_EN
  // Fewest attempts of any won game; only reset restores the sentinel.
  always_ff @(posedge clk) begin
    if (!rst)
      best_tries <= '1;
    else if (accept && win_hit && (tries_inc < best_tries))
      best_tries <= tries_inc;
  end
`else
  assign best_tries = '0;
`endif

endmodule
